complex_mult_seq: RTL and testbench

//  Sequential signed complex multiplier: (re_a + j*im_a) * (re_b + j*im_b), or * conj(b) when conj_in=1.

---
 rtl/complex_mult_seq.sv | 201 ++++++++++++++++++++
 tb/tb_complex_mult_seq.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_mult_seq.sv
// complex_mult_seq
//   Sequential signed complex multiplier: a*b, or a*conj(b) when conj_in=1.
//   One registered multiplier is time-shared over the three Gauss partial
//   products, giving one result every four cycles at full throughput.
//   Results are rounded half-up after an arithmetic right shift by SHIFT.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready combinational, no in_valid path)
//   conj_in               multiply by conj(b); captured with the sample
//   re_a, im_a            operand a (signed, DW bits)
//   re_b, im_b            operand b (signed, DW bits)
//   out_valid / out_ready output handshake; result held until accepted
//   re_out, im_out        result (signed, OW bits)
//   busy                  FSM not idle
module complex_mult_seq #(
   parameter  int unsigned DW    = 8,
   parameter  int unsigned SHIFT = 0,
   localparam int unsigned OW    = 2*DW + 1 - SHIFT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 conj_in,
   input  logic signed [DW-1:0] re_a,
   input  logic signed [DW-1:0] im_a,
   input  logic signed [DW-1:0] re_b,
   input  logic signed [DW-1:0] im_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [OW-1:0] re_out,
   output logic signed [OW-1:0] im_out,
   output logic                 busy
);

   localparam int unsigned PW = 2*DW + 2;   // product / partial-sum width
   localparam int unsigned YW = DW + 2;     // wide multiplier operand width

   // Half-LSB rounding constant; evaluates to zero when SHIFT == 0
   localparam logic signed [PW-1:0] RND = (PW'(1) << SHIFT) >> 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL1 = 3'd1,
      MUL2 = 3'd2,
      MUL3 = 3'd3,
      FIN  = 3'd4
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   accept;
   logic   fin_wr;

   // Captured operands: a=re_a, b=im_a, c=re_b, d=+/-im_b (one bit wider)
   logic signed [DW-1:0] op_a;
   logic signed [DW-1:0] op_b;
   logic signed [DW-1:0] op_c;
   logic signed [DW:0]   op_d;

   // Partial products
   logic signed [PW-1:0] p_reg;
   logic signed [PW-1:0] k1_reg;
   logic signed [PW-1:0] k2_reg;

   // Shared multiplier operands and product
   logic signed [DW-1:0] mul_x;
   logic signed [YW-1:0] mul_y;
   logic signed [PW-1:0] prod;

   logic signed [DW:0]   im_b_ext;
   logic signed [DW:0]   d_in;

   // Round half-up, arithmetic shift, truncate to output width
   function automatic logic signed [OW-1:0] rnd(input logic signed [PW-1:0] x);
      logic signed [PW-1:0] t;
      t = (x + RND) >>> SHIFT;
      return t[OW-1:0];
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake control
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      fin_wr    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = MUL1;
            end
         end
         MUL1: state_nxt = MUL2;
         MUL2: state_nxt = MUL3;
         MUL3: state_nxt = FIN;
         FIN: begin
            // Result slot is free if empty or being drained this cycle
            if (!out_valid || out_ready) begin
               fin_wr    = 1'b1;
               in_ready  = 1'b1;
               state_nxt = in_valid ? MUL1 : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (!rst_n) begin
         in_ready = 1'b0;
         fin_wr   = 1'b0;
      end
   end

   assign accept = in_valid && in_ready;
   assign busy   = (state != IDLE);

   // Conjugation folded into d; the extra bit keeps -(-2^(DW-1)) exact
   always_comb begin
      im_b_ext = (DW+1)'(im_b);
      d_in     = conj_in ? -im_b_ext : im_b_ext;
   end

   // Operand select for the shared multiplier: k1=c(a+b), k2=a(d-c), k3=b(c+d)
   always_comb begin
      mul_x = '0;
      mul_y = '0;
      case (state)
         MUL1: begin
            mul_x = op_c;
            mul_y = YW'(op_a) + YW'(op_b);
         end
         MUL2: begin
            mul_x = op_a;
            mul_y = YW'(op_d) - YW'(op_c);
         end
         MUL3: begin
            mul_x = op_b;
            mul_y = YW'(op_c) + YW'(op_d);
         end
         default: begin
            mul_x = '0;
            mul_y = '0;
         end
      endcase
      prod = PW'(mul_x) * PW'(mul_y);
   end

   // Datapath: operand capture, partial-product pipeline and result register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_a      <= '0;
         op_b      <= '0;
         op_c      <= '0;
         op_d      <= '0;
         p_reg     <= '0;
         k1_reg    <= '0;
         k2_reg    <= '0;
         re_out    <= '0;
         im_out    <= '0;
         out_valid <= 1'b0;
      end else begin
         if (accept) begin
            op_a <= re_a;
            op_b <= im_a;
            op_c <= re_b;
            op_d <= d_in;
         end

         case (state)
            MUL1: p_reg <= prod;
            MUL2: begin
               k1_reg <= p_reg;
               p_reg  <= prod;
            end
            MUL3: begin
               k2_reg <= p_reg;
               p_reg  <= prod;
            end
            default: ;
         endcase

         // A new result takes priority over clearing on a downstream transfer
         if (fin_wr) begin
            re_out    <= rnd(k1_reg - p_reg);
            im_out    <= rnd(k1_reg + k2_reg);
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_complex_mult_seq.sv
// tb_complex_mult_seq
//   Directed bench for complex_mult_seq: an unscaled instance (SHIFT=0) and a
//   scaled instance (SHIFT=4). Expected results come from a plain arithmetic
//   complex-multiply model queued on each input transfer and checked against
//   the outputs on every cycle they are valid.
module tb_complex_mult_seq;

   localparam int unsigned DW  = 8;
   localparam int unsigned OW0 = 2*DW + 1;
   localparam int unsigned OW4 = 2*DW + 1 - 4;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Unscaled instance
   logic                  u0_in_valid, u0_in_ready, u0_conj;
   logic signed [DW-1:0]  u0_re_a, u0_im_a, u0_re_b, u0_im_b;
   logic                  u0_out_valid, u0_out_ready, u0_busy;
   logic signed [OW0-1:0] u0_re_out, u0_im_out;

   // Scaled instance
   logic                  u4_in_valid, u4_in_ready, u4_conj;
   logic signed [DW-1:0]  u4_re_a, u4_im_a, u4_re_b, u4_im_b;
   logic                  u4_out_valid, u4_out_ready, u4_busy;
   logic signed [OW4-1:0] u4_re_out, u4_im_out;

   complex_mult_seq #(.DW(DW), .SHIFT(0)) u0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(u0_in_valid), .in_ready(u0_in_ready), .conj_in(u0_conj),
      .re_a(u0_re_a), .im_a(u0_im_a), .re_b(u0_re_b), .im_b(u0_im_b),
      .out_valid(u0_out_valid), .out_ready(u0_out_ready),
      .re_out(u0_re_out), .im_out(u0_im_out), .busy(u0_busy)
   );

   complex_mult_seq #(.DW(DW), .SHIFT(4)) u4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(u4_in_valid), .in_ready(u4_in_ready), .conj_in(u4_conj),
      .re_a(u4_re_a), .im_a(u4_im_a), .re_b(u4_re_b), .im_b(u4_im_b),
      .out_valid(u4_out_valid), .out_ready(u4_out_ready),
      .re_out(u4_re_out), .im_out(u4_im_out), .busy(u4_busy)
   );

   int vectors     = 0;
   int miscompares = 0;
   int last_acc    = 0;

   longint q0_re[$], q0_im[$], q4_re[$], q4_im[$];
   longint m_re, m_im, pin_re, pin_im;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint rnd(input longint x, input int sh);
      if (sh == 0) return x;
      return (x + (longint'(1) <<< (sh - 1))) >>> sh;
   endfunction

   // (ar + j ai) * (br + j bi), or times conj(b), then scaled
   function automatic void model(input longint ar, input longint ai,
                                 input longint br, input longint bi,
                                 input bit cj, input int sh,
                                 output longint re, output longint im);
      longint bim;
      bim = cj ? -bi : bi;
      re  = rnd(ar * br - ai * bim, sh);
      im  = rnd(ar * bim + ai * br, sh);
   endfunction

   // Scoreboard: push on input transfer, check every valid output cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         q0_re.delete(); q0_im.delete();
         q4_re.delete(); q4_im.delete();
      end else begin
         if (u0_out_valid) begin
            if (q0_re.size() == 0) begin
               check("u0 out_valid with no pending result", u0_out_valid, 0);
            end else begin
               check("u0 re_out", u0_re_out, q0_re[0]);
               check("u0 im_out", u0_im_out, q0_im[0]);
               if (u0_out_ready) begin
                  void'(q0_re.pop_front());
                  void'(q0_im.pop_front());
               end
            end
         end
         if (u4_out_valid) begin
            if (q4_re.size() == 0) begin
               check("u4 out_valid with no pending result", u4_out_valid, 0);
            end else begin
               check("u4 re_out", u4_re_out, q4_re[0]);
               check("u4 im_out", u4_im_out, q4_im[0]);
               if (u4_out_ready) begin
                  void'(q4_re.pop_front());
                  void'(q4_im.pop_front());
               end
            end
         end
         if (u0_in_valid && u0_in_ready) begin
            model(u0_re_a, u0_im_a, u0_re_b, u0_im_b, u0_conj, 0, m_re, m_im);
            q0_re.push_back(m_re);
            q0_im.push_back(m_im);
         end
         if (u4_in_valid && u4_in_ready) begin
            model(u4_re_a, u4_im_a, u4_re_b, u4_im_b, u4_conj, 4, m_re, m_im);
            q4_re.push_back(m_re);
            q4_im.push_back(m_im);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one sample and hold it until transferred; returns just after the accept edge
   task automatic send(input bit sel4, input int ar, input int ai,
                       input int br, input int bi, input bit cj);
      int n;
      if (!sel4) begin
         u0_re_a = DW'(ar); u0_im_a = DW'(ai);
         u0_re_b = DW'(br); u0_im_b = DW'(bi);
         u0_conj = cj;      u0_in_valid = 1'b1;
      end else begin
         u4_re_a = DW'(ar); u4_im_a = DW'(ai);
         u4_re_b = DW'(br); u4_im_b = DW'(bi);
         u4_conj = cj;      u4_in_valid = 1'b1;
      end
      n = 0;
      forever begin
         @(negedge clk);
         if (sel4 ? u4_in_ready : u0_in_ready) break;
         n++;
         if (n > 40) begin
            check("send accept timeout cycles", n, 0);
            break;
         end
      end
      last_acc = cyc;
      step();
      if (!sel4) u0_in_valid = 1'b0;
      else       u4_in_valid = 1'b0;
   endtask

   // Wait for out_valid; n = number of falling edges observed
   task automatic wait_out(input bit sel4, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(sel4 ? u4_out_valid : u0_out_valid) && n < 40);
      if (!(sel4 ? u4_out_valid : u0_out_valid))
         check("wait out_valid timeout cycles", n, 0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0_re.size() != 0 || q4_re.size() != 0) && n < 80) begin
         @(negedge clk);
         n++;
      end
      check("drain u0 pending", q0_re.size(), 0);
      check("drain u4 pending", q4_re.size(), 0);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct { int ar; int ai; int br; int bi; bit cj; } vec_t;
   vec_t b2b[6];
   int   acc_cyc[6];
   int   n;

   initial begin
      rst_n = 1'b0;
      u0_in_valid = 1'b0; u0_conj = 1'b0; u0_out_ready = 1'b1;
      u0_re_a = '0; u0_im_a = '0; u0_re_b = '0; u0_im_b = '0;
      u4_in_valid = 1'b0; u4_conj = 1'b0; u4_out_ready = 1'b1;
      u4_re_a = '0; u4_im_a = '0; u4_re_b = '0; u4_im_b = '0;

      b2b[0] = '{ 1,  1,  1,  1, 1'b0};
      b2b[1] = '{-5,  7,  3, -2, 1'b1};
      b2b[2] = '{127, -128, -128, 127, 1'b0};
      b2b[3] = '{ 0, 10, -10, 0, 1'b0};
      b2b[4] = '{-1, -1, -1, -1, 1'b1};
      b2b[5] = '{100, 50, -60, 90, 1'b0};

      // Model pinned to hand-computed values
      model(3, 4, 5, -2, 1'b0, 0, pin_re, pin_im);
      check("model 3+4j * 5-2j re", pin_re, 23);
      check("model 3+4j * 5-2j im", pin_im, 14);
      model(-128, -128, -128, -128, 1'b1, 0, pin_re, pin_im);
      check("model extreme conj re", pin_re, 32768);
      check("model extreme conj im", pin_im, 0);
      model(-9, 0, 1, 0, 1'b0, 4, pin_re, pin_im);
      check("model shift4 -9 re", pin_re, -1);

      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("in_ready during reset", u0_in_ready, 0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("reset out_valid", u0_out_valid, 0);
      check("reset re_out", u0_re_out, 0);
      check("reset im_out", u0_im_out, 0);
      check("reset busy", u0_busy, 0);
      check("idle in_ready", u0_in_ready, 1);
      step();

      // Basic product and latency
      send(1'b0, 3, 4, 5, -2, 1'b0);
      wait_out(1'b0, n);
      check("latency edges after accept", n - 1, 4);
      check("basic re", u0_re_out, 23);
      check("basic im", u0_im_out, 14);
      step();

      // Conjugate
      send(1'b0, 3, 4, 5, -2, 1'b1);
      wait_out(1'b0, n);
      check("conj re", u0_re_out, 7);
      check("conj im", u0_im_out, 26);
      step();

      // Extremes
      send(1'b0, -128, -128, -128, -128, 1'b0);
      wait_out(1'b0, n);
      check("extreme re", u0_re_out, 0);
      check("extreme im", u0_im_out, 32768);
      step();
      send(1'b0, -128, -128, -128, -128, 1'b1);
      wait_out(1'b0, n);
      check("extreme conj re", u0_re_out, 32768);
      check("extreme conj im", u0_im_out, 0);
      step();

      // Back-to-back, in_valid held high across samples
      for (int i = 0; i < 6; i++) begin
         send(1'b0, b2b[i].ar, b2b[i].ai, b2b[i].br, b2b[i].bi, b2b[i].cj);
         acc_cyc[i] = last_acc;
      end
      for (int i = 1; i < 6; i++) check("b2b accept spacing", acc_cyc[i] - acc_cyc[i-1], 4);
      drain();

      // Stall with two samples queued
      u0_out_ready = 1'b0;
      send(1'b0, 3, 4, 5, -2, 1'b0);
      send(1'b0, 2, -1, -3, 7, 1'b1);
      repeat (6) @(negedge clk);
      check("stall in_ready", u0_in_ready, 0);
      check("stall busy", u0_busy, 1);
      check("stall out_valid", u0_out_valid, 1);
      check("stall held re", u0_re_out, 23);
      check("stall held im", u0_im_out, 14);
      step();
      u0_out_ready = 1'b1;
      wait_out(1'b0, n);
      @(negedge clk);
      check("post-stall second re", u0_re_out, -13);
      check("post-stall second im", u0_im_out, -11);
      drain();

      // Reset in MUL2 with a held output
      u0_out_ready = 1'b0;
      send(1'b0, 1, 2, 3, 4, 1'b0);
      wait_out(1'b0, n);
      check("held before reset re", u0_re_out, -5);
      step();
      send(1'b0, 5, 6, 7, 8, 1'b0);
      step();
      rst_n = 1'b0;
      step();
      @(negedge clk);
      check("mid-op reset out_valid", u0_out_valid, 0);
      check("mid-op reset re_out", u0_re_out, 0);
      check("mid-op reset im_out", u0_im_out, 0);
      check("mid-op reset busy", u0_busy, 0);
      check("mid-op reset in_ready", u0_in_ready, 0);
      step();
      rst_n = 1'b1;
      u0_out_ready = 1'b1;
      send(1'b0, -7, 3, 6, -5, 1'b0);
      wait_out(1'b0, n);
      check("after reset re", u0_re_out, -27);
      check("after reset im", u0_im_out, 53);
      step();

      // Scaled instance
      send(1'b1, 3, 4, 5, -2, 1'b0);
      wait_out(1'b1, n);
      check("shift4 re", u4_re_out, 1);
      check("shift4 im", u4_im_out, 1);
      step();
      send(1'b1, -9, 0, 1, 0, 1'b0);
      wait_out(1'b1, n);
      check("shift4 neg re", u4_re_out, -1);
      check("shift4 neg im", u4_im_out, 0);
      step();

      drain();
      check("final u4 busy", u4_busy, 0);
      check("final u0 busy", u0_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
